// File: rtl/dallanma_pkg.sv
// Shared types and constants for the branch resolution stage.
package dallanma_pkg;

  localparam int PS_W  = 32;
  localparam int ARTIS = 4;

  typedef struct packed {
    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] buyruk;
    logic            dallan;
    logic [PS_W-1:0] dallan_ps;
  } ongoru_girdisi_t;

  typedef enum logic {
    CALIS   = 1'b0,
    TEMIZLE = 1'b1
  } cozucu_durum_t;

endpackage

// File: rtl/ongoru_fifo.sv
// In-order prediction queue; head visible combinationally, push/pop take effect next edge.
// Flush empties the queue and wins over a same-cycle push; push when full / pop when empty are ignored.
module ongoru_fifo #(
  parameter int DERINLIK = 4,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);

  localparam int AW = $clog2(DERINLIK);

  logic [W-1:0]  mem_q [DERINLIK];
  logic [W-1:0]  mem_d [DERINLIK];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          yaz, oku;

  assign full     = (cnt_q == (AW+1)'(DERINLIK));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    yaz   = push && !full;
    oku   = pop && !empty;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (yaz) begin
        mem_d[wr_q] = push_dat;
        wr_d        = wr_q + 1'b1;
      end
      if (oku) begin
        rd_d = rd_q + 1'b1;
      end
      if (yaz && !oku) begin
        cnt_d = cnt_q + 1'b1;
      end else if (oku && !yaz) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dallanma_cozucu.sv
// Resolves queued branch predictions against execute outcomes; results appear one cycle after resolution.
// tahmin_hazir drops when the queue is full or while flushing after a mispredict.
module dallanma_cozucu
  import dallanma_pkg::*;
#(
  parameter int DERINLIK = 4,
  parameter int PS_W     = 32,
  parameter int SAYAC_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tahmin_gecerli,
  input  logic [PS_W-1:0]    tahmin_ps,
  input  logic [PS_W-1:0]    tahmin_buyruk,
  input  logic               tahmin_dallan,
  input  logic [PS_W-1:0]    tahmin_dallan_ps,
  output logic               tahmin_hazir,
  input  logic               yurut_gecerli_i,
  input  logic               yurut_dallan_i,
  input  logic [PS_W-1:0]    yurut_hedef_ps_i,
  output logic               guncelle_gecerli,
  output logic [PS_W-1:0]    guncelle_ps,
  output logic [PS_W-1:0]    guncelle_buyruk,
  output logic [PS_W-1:0]    guncelle_dallan_ps,
  output logic               guncelle_dallan,
  output logic               yanlis_ongoru,
  output logic [PS_W-1:0]    duzelt_ps,
  output logic [SAYAC_W-1:0] toplam_sayac,
  output logic [SAYAC_W-1:0] dogru_sayac,
  output logic               hata
);

  localparam int GW = $bits(ongoru_girdisi_t);

  ongoru_girdisi_t giris, bas;
  logic [GW-1:0]   bas_vec;
  logic            dolu, bos, push, pop, yanlis;
  logic [PS_W-1:0] tahmin_sonraki, gercek_sonraki;

  cozucu_durum_t      durum_q, durum_d;
  logic               ggec_q, ggec_d, gdal_q, gdal_d;
  logic [PS_W-1:0]    gps_q, gps_d, gbuy_q, gbuy_d, gdps_q, gdps_d;
  logic               yanlis_q, yanlis_d, hata_q, hata_d;
  logic [PS_W-1:0]    duzelt_q, duzelt_d;
  logic [SAYAC_W-1:0] toplam_q, toplam_d, dogru_q, dogru_d;

  ongoru_fifo #(.DERINLIK(DERINLIK), .W(GW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (giris),
    .pop      (pop),
    .flush    (yanlis),
    .full     (dolu),
    .empty    (bos),
    .head_dat (bas_vec)
  );

  assign bas          = ongoru_girdisi_t'(bas_vec);
  assign tahmin_hazir = (durum_q == CALIS) && !dolu;

  always_comb begin
    giris           = '{ps: tahmin_ps, buyruk: tahmin_buyruk,
                        dallan: tahmin_dallan, dallan_ps: tahmin_dallan_ps};
    push            = tahmin_gecerli && tahmin_hazir;
    pop             = yurut_gecerli_i && !bos;
    tahmin_sonraki  = bas.dallan ? bas.dallan_ps : bas.ps + PS_W'(ARTIS);
    gercek_sonraki  = yurut_dallan_i ? yurut_hedef_ps_i : bas.ps + PS_W'(ARTIS);
    yanlis          = pop && ((bas.dallan != yurut_dallan_i) ||
                              (tahmin_sonraki != gercek_sonraki));

    ggec_d   = pop;
    gps_d    = pop ? bas.ps : '0;
    gbuy_d   = pop ? bas.buyruk : '0;
    gdal_d   = pop && yurut_dallan_i;
    gdps_d   = pop ? yurut_hedef_ps_i : '0;
    yanlis_d = yanlis;
    duzelt_d = yanlis ? gercek_sonraki : duzelt_q;
    toplam_d = toplam_q;
    dogru_d  = dogru_q;
    if (pop && (toplam_q != '1)) begin
      toplam_d = toplam_q + 1'b1;
    end
    if (pop && !yanlis && (dogru_q != '1)) begin
      dogru_d = dogru_q + 1'b1;
    end

    // A refused push only counts as an error outside the post-flush bubble.
    hata_d = hata_q
           | (tahmin_gecerli && !tahmin_hazir && (durum_q == CALIS))
           | (yurut_gecerli_i && bos);

    durum_d = (durum_q == TEMIZLE) ? CALIS : (yanlis ? TEMIZLE : CALIS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q  <= CALIS;
      ggec_q   <= 1'b0;
      gps_q    <= '0;
      gbuy_q   <= '0;
      gdal_q   <= 1'b0;
      gdps_q   <= '0;
      yanlis_q <= 1'b0;
      duzelt_q <= '0;
      toplam_q <= '0;
      dogru_q  <= '0;
      hata_q   <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      ggec_q   <= ggec_d;
      gps_q    <= gps_d;
      gbuy_q   <= gbuy_d;
      gdal_q   <= gdal_d;
      gdps_q   <= gdps_d;
      yanlis_q <= yanlis_d;
      duzelt_q <= duzelt_d;
      toplam_q <= toplam_d;
      dogru_q  <= dogru_d;
      hata_q   <= hata_d;
    end
  end

  assign guncelle_gecerli   = ggec_q;
  assign guncelle_ps        = gps_q;
  assign guncelle_buyruk    = gbuy_q;
  assign guncelle_dallan    = gdal_q;
  assign guncelle_dallan_ps = gdps_q;
  assign yanlis_ongoru      = yanlis_q;
  assign duzelt_ps          = duzelt_q;
  assign toplam_sayac       = toplam_q;
  assign dogru_sayac        = dogru_q;
  assign hata               = hata_q;

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Bench for dallanma_cozucu: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_dallanma_cozucu;

  logic        clk = 1'b0;
  logic        rst;
  logic        tahmin_gecerli, tahmin_dallan, tahmin_hazir;
  logic [31:0] tahmin_ps, tahmin_buyruk, tahmin_dallan_ps;
  logic        yurut_gecerli_i, yurut_dallan_i;
  logic [31:0] yurut_hedef_ps_i;
  logic        guncelle_gecerli, guncelle_dallan, yanlis_ongoru, hata;
  logic [31:0] guncelle_ps, guncelle_buyruk, guncelle_dallan_ps, duzelt_ps;
  logic [15:0] toplam_sayac, dogru_sayac;

  dallanma_cozucu #(.DERINLIK(4), .PS_W(32), .SAYAC_W(16)) dut (
    .clk(clk), .rst(rst),
    .tahmin_gecerli(tahmin_gecerli), .tahmin_ps(tahmin_ps), .tahmin_buyruk(tahmin_buyruk),
    .tahmin_dallan(tahmin_dallan), .tahmin_dallan_ps(tahmin_dallan_ps), .tahmin_hazir(tahmin_hazir),
    .yurut_gecerli_i(yurut_gecerli_i), .yurut_dallan_i(yurut_dallan_i),
    .yurut_hedef_ps_i(yurut_hedef_ps_i),
    .guncelle_gecerli(guncelle_gecerli), .guncelle_ps(guncelle_ps),
    .guncelle_buyruk(guncelle_buyruk), .guncelle_dallan_ps(guncelle_dallan_ps),
    .guncelle_dallan(guncelle_dallan), .yanlis_ongoru(yanlis_ongoru), .duzelt_ps(duzelt_ps),
    .toplam_sayac(toplam_sayac), .dogru_sayac(dogru_sayac), .hata(hata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of outstanding predictions plus expected outputs.
  typedef struct {
    logic [31:0] ps;
    logic [31:0] buy;
    logic        dl;
    logic [31:0] dps;
  } ent_t;

  ent_t        q[$];
  bit          m_bubble;
  logic        e_gg, e_gd, e_yo, e_hata;
  logic [31:0] e_gps, e_gbuy, e_gdps, e_duz;
  logic [15:0] e_top, e_dog;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_bubble = 0;
      e_gg = 0; e_gd = 0; e_yo = 0; e_hata = 0;
      e_gps = 0; e_gbuy = 0; e_gdps = 0; e_duz = 0;
      e_top = 0; e_dog = 0;
    end else begin
      bit          accept, miss;
      ent_t        e;
      logic [31:0] pred, act;
      accept = !m_bubble && (q.size() < 4);
      miss   = 0;
      e_gg = 0; e_gd = 0; e_yo = 0; e_gps = 0; e_gbuy = 0; e_gdps = 0;
      if (yurut_gecerli_i && q.size() == 0) e_hata = 1;
      if (tahmin_gecerli && !accept && !m_bubble) e_hata = 1;
      if (yurut_gecerli_i && q.size() > 0) begin
        e    = q.pop_front();
        pred = e.dl ? e.dps : e.ps + 32'd4;
        act  = yurut_dallan_i ? yurut_hedef_ps_i : e.ps + 32'd4;
        miss = (e.dl != yurut_dallan_i) || (pred != act);
        e_gg = 1; e_gps = e.ps; e_gbuy = e.buy; e_gd = yurut_dallan_i; e_gdps = yurut_hedef_ps_i;
        if (e_top != 16'hFFFF) e_top = e_top + 1;
        if (!miss && e_dog != 16'hFFFF) e_dog = e_dog + 1;
        if (miss) begin
          e_yo  = 1;
          e_duz = act;
        end
      end
      if (miss) q.delete();
      else if (tahmin_gecerli && accept)
        q.push_back('{ps: tahmin_ps, buy: tahmin_buyruk, dl: tahmin_dallan, dps: tahmin_dallan_ps});
      m_bubble = miss;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hazir", {31'd0, tahmin_hazir}, {31'd0, (!m_bubble && q.size() < 4)});
      chk("gg", {31'd0, guncelle_gecerli}, {31'd0, e_gg});
      chk("gps", guncelle_ps, e_gps);
      chk("gbuy", guncelle_buyruk, e_gbuy);
      chk("gdal", {31'd0, guncelle_dallan}, {31'd0, e_gd});
      chk("gdps", guncelle_dallan_ps, e_gdps);
      chk("yanlis", {31'd0, yanlis_ongoru}, {31'd0, e_yo});
      chk("duzelt", duzelt_ps, e_duz);
      chk("toplam", {16'd0, toplam_sayac}, {16'd0, e_top});
      chk("dogru", {16'd0, dogru_sayac}, {16'd0, e_dog});
      chk("hata", {31'd0, hata}, {31'd0, e_hata});
    end
  end

  task automatic drive(input bit tg, input logic [31:0] ps, input bit dl, input logic [31:0] dps,
                       input bit yg, input bit yd, input logic [31:0] yh);
    tahmin_gecerli   = tg;
    tahmin_ps        = ps;
    tahmin_buyruk    = ps ^ 32'hA5A5_0013;
    tahmin_dallan    = dl;
    tahmin_dallan_ps = dps;
    yurut_gecerli_i  = yg;
    yurut_dallan_i   = yd;
    yurut_hedef_ps_i = yh;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_rst();
    rst = 1;
    idle();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    chk_en = 1;
    chk("rst_hazir", {31'd0, tahmin_hazir}, 32'd1);
    chk("rst_gg", {31'd0, guncelle_gecerli}, 32'd0);
    chk("rst_toplam", {16'd0, toplam_sayac}, 32'd0);
    chk("rst_duzelt", duzelt_ps, 32'd0);

    // Correct taken prediction
    drive(1, 32'h100, 1, 32'h200, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h200);
    chk("t1_gg", {31'd0, guncelle_gecerli}, 32'd1);
    chk("t1_yo", {31'd0, yanlis_ongoru}, 32'd0);
    chk("t1_dogru", {16'd0, dogru_sayac}, 32'd1);
    chk("t1_toplam", {16'd0, toplam_sayac}, 32'd1);
    chk("t1_gps", guncelle_ps, 32'h100);
    idle();

    // Direction miss with a younger entry queued behind
    drive(1, 32'h100, 0, 32'h0, 0, 0, 0);
    drive(1, 32'h104, 1, 32'h300, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h300);
    chk("t2_yo", {31'd0, yanlis_ongoru}, 32'd1);
    chk("t2_duzelt", duzelt_ps, 32'h300);
    chk("t2_hazir", {31'd0, tahmin_hazir}, 32'd0);
    chk("t2_hata", {31'd0, hata}, 32'd0);
    idle();
    chk("t2_hazir_back", {31'd0, tahmin_hazir}, 32'd1);
    chk("t2_duzelt_hold", duzelt_ps, 32'h300);

    // Target miss, then not-taken miss
    drive(1, 32'h100, 1, 32'h200, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h240);
    chk("t3_yo", {31'd0, yanlis_ongoru}, 32'd1);
    chk("t3_duzelt", duzelt_ps, 32'h240);
    idle();
    drive(1, 32'h100, 1, 32'h200, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    chk("t3_nt_duzelt", duzelt_ps, 32'h104);
    chk("t3_nt_dogru", {16'd0, dogru_sayac}, 32'd1);
    idle();

    // Full queue, overflow push, ordered drain
    for (int i = 0; i < 4; i++) drive(1, 32'h1000 + 32'(16 * i), 0, 32'hDEAD, 0, 0, 0);
    chk("t4_full", {31'd0, tahmin_hazir}, 32'd0);
    chk("t4_hata0", {31'd0, hata}, 32'd0);
    drive(1, 32'h2000, 0, 0, 0, 0, 0);
    chk("t4_hata1", {31'd0, hata}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'h0);
      chk("t4_order", guncelle_ps, 32'h1000 + 32'(16 * i));
      chk("t4_yo", {31'd0, yanlis_ongoru}, 32'd0);
    end
    idle();
    pulse_rst();

    // Mispredict with simultaneous push, then resolve on empty
    drive(1, 32'h500, 1, 32'h600, 0, 0, 0);
    drive(1, 32'h700, 0, 32'h0, 1, 0, 32'h0);
    chk("t5_yo", {31'd0, yanlis_ongoru}, 32'd1);
    chk("t5_duzelt", duzelt_ps, 32'h504);
    idle();
    drive(0, 0, 0, 0, 1, 1, 32'h0);
    chk("t5_hata", {31'd0, hata}, 32'd1);
    chk("t5_toplam", {16'd0, toplam_sayac}, 32'd1);
    chk("t5_gg", {31'd0, guncelle_gecerli}, 32'd0);
    pulse_rst();

    // Reset mid-run with occupancy 3
    drive(1, 32'h40, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'h80 + 32'(4 * i), 0, 0, 0, 0, 0);
    chk("t6_pre", {16'd0, toplam_sayac}, 32'd1);
    rst = 1;
    drive(1, 32'h90, 0, 0, 1, 0, 0);
    rst = 0;
    chk("t6_toplam", {16'd0, toplam_sayac}, 32'd0);
    chk("t6_dogru", {16'd0, dogru_sayac}, 32'd0);
    chk("t6_gg", {31'd0, guncelle_gecerli}, 32'd0);
    chk("t6_hazir", {31'd0, tahmin_hazir}, 32'd1);
    idle();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit          tg, dl, yg, yd;
      logic [31:0] ps, dps, yh;
      rst = ($urandom_range(0, 299) == 0);
      tg  = $urandom_range(0, 1);
      ps  = {$urandom_range(0, 255), 2'b00};
      dl  = $urandom_range(0, 1);
      dps = {$urandom_range(0, 255), 2'b00};
      if (q.size() > 0) yg = ($urandom_range(0, 2) != 0);
      else              yg = ($urandom_range(0, 19) == 0);
      yd = $urandom_range(0, 1);
      yh = {$urandom_range(0, 255), 2'b00};
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        yd = q[0].dl;
        if (q[0].dl) yh = q[0].dps;
      end
      drive(tg, ps, dl, dps, yg, yd, yh);
    end
    rst = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dallanma_cozucu.md
# dallanma_cozucu

Branch resolution stage directly downstream of the `ongorucu` branch predictor. It buffers each prediction (`sonuc_dallan`/`sonuc_dallan_ps`) in a small in-order queue until the execute stage reports the real outcome. It then compares the two, raises a misprediction with the correct redirect PC, and drives the predictor's `yurut_*` update port. It also keeps total/correct prediction counters for accuracy reporting.

## Interface
- `DERINLIK`, 4: in-flight prediction queue depth; power of two, ≥2.
- `PS_W`, 32: PC/instruction width.
- `SAYAC_W`, 16: statistics counter width.

- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tahmin_gecerli`  in  1: prediction valid this cycle.
- `tahmin_ps`  in  PS_W: PC of predicted branch.
- `tahmin_buyruk`  in  PS_W: branch instruction word.
- `tahmin_dallan`  in  1: predicted taken.
- `tahmin_dallan_ps`  in  PS_W: predicted target.
- `tahmin_hazir`  out  1: queue can accept a prediction.
- `yurut_gecerli_i`  in  1: execute outcome for oldest queued branch.
- `yurut_dallan_i`  in  1: actual taken.
- `yurut_hedef_ps_i`  in  PS_W: actual taken target.
- `guncelle_gecerli`  out  1: update strobe to predictor `yurut_gecerli`.
- `guncelle_ps`, `guncelle_buyruk`, `guncelle_dallan_ps`  out  PS_W: update payload.
- `guncelle_dallan`  out  1: actual direction for update.
- `yanlis_ongoru`  out  1: one-cycle misprediction pulse.
- `duzelt_ps`  out  PS_W: correct next PC, valid with `yanlis_ongoru`.
- `toplam_sayac`, `dogru_sayac`  out  SAYAC_W: resolved / correctly predicted branches.
- `hata`  out  1: sticky protocol error.

## Operation
- Queue: in-order FIFO, entry = {ps, buyruk, dallan, dallan_ps}; occupancy counter 0..DERINLIK, pointers wrap modulo DERINLIK.
- Push: `tahmin_gecerli && tahmin_hazir`. `tahmin_gecerli` while `!tahmin_hazir` → entry dropped, `hata`←1.
- Pop: `yurut_gecerli_i` resolves the head entry. `yurut_gecerli_i` with empty queue → no action, `hata`←1.
- Predicted next PC = dallan ? dallan_ps : ps+4. Actual next PC = `yurut_dallan_i` ? `yurut_hedef_ps_i` : ps+4. Adds are modulo 2^PS_W.
- Mispredict = direction differs OR next PCs differ.
- Every resolution: `toplam_sayac`+1; if correct, `dogru_sayac`+1. Both saturate at all-ones.
- Mispredict: all entries younger than the head are wrong-path and are flushed (occupancy←0). A push in the same cycle is discarded, without setting `hata`. FSM enters TEMIZLE.
- FSM: CALIS → TEMIZLE on mispredict; TEMIZLE → CALIS unconditionally after 1 cycle. In TEMIZLE, `tahmin_hazir`=0 and `tahmin_gecerli` is ignored without `hata`. A `yurut_gecerli_i` in TEMIZLE sets `hata`, because the queue is empty.
- `tahmin_hazir` = (state==CALIS) && occupancy<DERINLIK. Simultaneous push and non-mispredicting pop when full is not allowed, because `tahmin_hazir` is already 0.

## Timing
- Reset values: all outputs 0, state CALIS, queue empty, pointers 0. `tahmin_hazir` reads 1 in the first cycle after reset.
- Push in cycle N → entry resolvable from cycle N+1. Push and pop of the same entry in one cycle is not allowed.
- Resolution in cycle N → in N+1, registered outputs show:
  - `guncelle_*` for one cycle;
  - `yanlis_ongoru`/`duzelt_ps`, if mispredicted;
  - updated counters.
- `duzelt_ps` holds its last value when `yanlis_ongoru`=0. `guncelle_*` payload is 0 when `guncelle_gecerli`=0.
- `rst` asserted mid-operation: next edge empties the queue, clears counters and `hata`, and drops any pending update pulse.

## Structure
- `dallanma_pkg`:
  - `PS_W` default;
  - `ARTIS=4` (PC increment);
  - packed struct `ongoru_girdisi_t` {ps, buyruk, dallan, dallan_ps};
  - enum `cozucu_durum_t` {CALIS, TEMIZLE}.
- Sub-module `ongoru_fifo`: parameterised synchronous FIFO with push, pop, flush, full, empty, head. Flush has priority over push.
- Top holds the compare logic, FSM, counters and output registers.

## Test plan
- Correct taken: push {ps=0x100, dallan=1, dallan_ps=0x200}, then resolve taken/0x200 → next cycle `guncelle_gecerli`=1, `yanlis_ongoru`=0, `dogru_sayac`=1, `toplam_sayac`=1.
- Direction miss: push {0x100, dallan=0} plus a second entry, then resolve taken/0x300 → `yanlis_ongoru`=1, `duzelt_ps`=0x300; queue empty; `tahmin_hazir`=0 for one cycle; `hata`=0.
- Target miss: predicted taken 0x200, actual taken 0x240 → mispredict, `duzelt_ps`=0x240. Not-taken miss: predicted taken 0x200, actual not-taken → `duzelt_ps`=0x104.
- Full queue: 4 pushes → `tahmin_hazir`=0; 5th push → `hata`=1 and occupancy stays 4. Four correct resolutions drain the queue in order, checked via `guncelle_ps` sequence.
- Simultaneous: mispredicting resolve and push in the same cycle → push discarded, occupancy 0. Resolve on empty queue → `hata`=1 and counters unchanged.
- Reset mid-run: with occupancy 3 and counters nonzero, pulse `rst` → all outputs 0, queue empty next cycle.
